// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity codes and the
// 16x oversample constant used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // XOR of the low dbit bits, inverted for odd parity.
    function automatic logic parity_bit(input logic [7:0] d, input int dbit, input int par);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < dbit) p = p ^ d[i];
        return (par == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity,
// SB_TICK-long stop. All timing is counted in 16x oversample ticks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_din,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_done
);

    // Codes other than even/odd fall back to no parity.
    localparam logic       HAS_PAR  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam logic [4:0] LAST_OS  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_SB  = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);

    tx_state_t  state;
    logic [4:0] s_cnt;
    logic [2:0] n_cnt;
    logic [7:0] b_reg;
    logic       par_reg;

    // tx, tx_ready and tx_done are loaded with the value for the state being
    // entered, so the line is always a flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            b_reg    <= '0;
            par_reg  <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        b_reg    <= tx_din;
                        par_reg  <= parity_bit(tx_din, DBIT, PARITY);
                        s_cnt    <= '0;
                        n_cnt    <= '0;
                        state    <= ST_START;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_OS) begin
                            s_cnt <= '0;
                            state <= ST_DATA;
                            tx    <= b_reg[0];
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_OS) begin
                            s_cnt <= '0;
                            b_reg <= b_reg >> 1;
                            if (n_cnt == LAST_BIT) begin
                                if (HAS_PAR) begin
                                    state <= ST_PAR;
                                    tx    <= par_reg;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                n_cnt <= n_cnt + 3'd1;
                                tx    <= b_reg[1];
                            end
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_OS) begin
                            s_cnt <= '0;
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_cnt == LAST_SB) begin
                            s_cnt    <= '0;
                            state    <= ST_IDLE;
                            tx       <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    s_cnt    <= '0;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
